// File: rtl/fnd_pkg.sv
// Shared constants, types and the segment encoder for the FND scan controller.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} for a common-anode display.
package fnd_pkg;

    localparam int unsigned BIN_W     = 14;
    localparam int unsigned BCD_W     = 16;
    localparam int unsigned DIGITS    = 4;
    localparam int unsigned SEG_W     = 8;
    localparam int unsigned MAX_VALUE = 9999;

    localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
    localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
    localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
    localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
    localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
    localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
    localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
    localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
    localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
    localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
    localparam logic [SEG_W-1:0] SEG_DASH  = 8'hBF;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
    localparam logic [DIGITS-1:0] COM_OFF  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } conv_state_e;

    // Attributes captured alongside the value at handshake time
    typedef struct packed {
        logic [DIGITS-1:0] dp;
        logic              lz_blank;
        logic              ovf;
    } req_attr_t;

    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Value handshake plus FND drive lines for one display controller.
interface fnd_scan_ctrl_if;
    import fnd_pkg::*;

    logic [BIN_W-1:0]  i_value;
    logic              i_valid;
    logic              o_ready;
    logic [DIGITS-1:0] i_dp;
    logic              i_lz_blank;
    logic              o_ovf;
    logic [DIGITS-1:0] fnd_com;
    logic [SEG_W-1:0]  fnd_data;

    modport master (
        output i_value, i_valid, i_dp, i_lz_blank,
        input  o_ready, o_ovf, fnd_com, fnd_data
    );

    modport slave (
        input  i_value, i_valid, i_dp, i_lz_blank,
        output o_ready, o_ovf, fnd_com, fnd_data
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock, BIN_W iterations,
// then a single LOAD cycle where done is high and bcd holds the result.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W);

    conv_state_e      state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // BCD field sits above the remaining binary bits in the shift register
    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int n = 0; n < int'(BCD_W / 4); n++) begin
            if (t[BIN_W + 4*n +: 4] >= 4'd5)
                t[BIN_W + 4*n +: 4] = t[BIN_W + 4*n +: 4] + 4'd3;
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = {BCD_W'(0), bin};
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = dabble(sr_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1))
                    state_d = ST_LOAD;
            end
            ST_LOAD:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit common-anode FND driver: value handshake, BCD conversion, blanking/DP/overflow
// formatting and time-multiplexed digit scan.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100_000
) (
    input logic            clk,
    input logic            reset,
    fnd_scan_ctrl_if.slave bus
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = $clog2(DIGITS);

    logic                         accept;
    logic                         conv_busy;
    logic                         conv_done;
    logic [BCD_W-1:0]             conv_bcd;
    logic [DIGITS-1:0][SEG_W-1:0] disp_new;
    logic                         tick;

    req_attr_t                    attr_q, attr_d;
    logic [DIGITS-1:0][SEG_W-1:0] disp_q, disp_d;
    logic                         ovf_q, ovf_d;
    logic [SCAN_W-1:0]            scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [DIGITS-1:0]            com_q, com_d;
    logic [SEG_W-1:0]             data_q, data_d;

    assign accept = bus.i_valid & ~conv_busy;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .bin   (bus.i_value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Format converted digits: blank leading zeros, then DP, overflow overrides all
    always_comb begin
        logic [3:0]       nib;
        logic [SEG_W-1:0] seg;
        logic             higher_nz;
        disp_new  = '0;
        higher_nz = 1'b0;
        for (int n = int'(DIGITS) - 1; n >= 0; n--) begin
            nib       = conv_bcd[4*n +: 4];
            higher_nz = higher_nz | (nib != 4'd0);
            seg       = bcd_to_seg(nib);
            if (attr_q.lz_blank && (n != 0) && !higher_nz)
                seg = SEG_BLANK;
            if (attr_q.dp[n])
                seg[SEG_W-1] = 1'b0;
            if (attr_q.ovf)
                seg = SEG_DASH;
            disp_new[n] = seg;
        end
    end

    always_comb begin
        attr_d     = attr_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        tick       = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));

        if (accept) begin
            attr_d.dp       = bus.i_dp;
            attr_d.lz_blank = bus.i_lz_blank;
            attr_d.ovf      = (bus.i_value > BIN_W'(MAX_VALUE));
        end
        if (conv_done) begin
            disp_d = disp_new;
            ovf_d  = attr_q.ovf;
        end
        if (tick) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 1'b1;
        end

        com_d  = ~(DIGITS'(1) << idx_q);
        data_d = disp_q[idx_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            attr_q     <= '0;
            disp_q     <= {DIGITS{SEG_BLANK}};
            ovf_q      <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            com_q      <= COM_OFF;
            data_q     <= SEG_BLANK;
        end else begin
            attr_q     <= attr_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            com_q      <= com_d;
            data_q     <= data_d;
        end
    end

    assign bus.o_ready  = ~conv_busy;
    assign bus.o_ovf    = ovf_q;
    assign bus.fnd_com  = com_q;
    assign bus.fnd_data = data_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: stimulus pushes expected displays, a monitor
// pops one on every conversion completion and checks the following scan round.
module tb_fnd_scan_ctrl;

    localparam int unsigned SCAN_DIV = 4;
    localparam int          WINDOW   = 4 * SCAN_DIV + 2;

    typedef struct packed {
        logic [3:0][7:0] seg;
        logic            ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    fnd_scan_ctrl_if bus ();

    fnd_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'h00;
        endcase
    endfunction

    // Expected display from decimal arithmetic on the value
    function automatic exp_t model(input int v, input logic [3:0] dp, input logic lz);
        exp_t       e;
        int         p;
        logic [7:0] s;
        p     = 1;
        e.ovf = (v > 9999);
        for (int n = 0; n < 4; n++) begin
            s = seg_of((v / p) % 10);
            if (lz && n > 0 && v < p) s = 8'hFF;
            if (dp[n]) s[7] = 1'b0;
            if (e.ovf) s = 8'hBF;
            e.seg[n] = s;
            p = p * 10;
        end
        return e;
    endfunction

    function automatic int com_to_idx(input logic [3:0] com);
        case (com)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Monitor: on each ready rise, pop one expectation and verify a full scan round
    initial begin : monitor
        logic prev_ready;
        exp_t e;
        logic [3:0] seen;
        int idx, last;
        prev_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ready = 1'b1;
                continue;
            end
            if (bus.o_ready && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_load: display updated with no pending request");
                end else begin
                    e = exp_q.pop_front();
                    check("o_ovf", 32'(bus.o_ovf), 32'(e.ovf));
                    seen = 4'b0000;
                    last = -1;
                    for (int c = 0; c < WINDOW; c++) begin
                        @(negedge clk);
                        if (reset) break;
                        idx = com_to_idx(bus.fnd_com);
                        check("com_onehot", 32'(idx >= 0), 32'd1);
                        if (idx >= 0) begin
                            if (last >= 0 && idx != last)
                                check("scan_order", 32'(idx), 32'((last + 1) % 4));
                            last = idx;
                            if (!seen[idx]) begin
                                check($sformatf("digit%0d", idx), 32'(bus.fnd_data), 32'(e.seg[idx]));
                                seen[idx] = 1'b1;
                            end
                        end
                    end
                    check("scan_cover", 32'(seen), 32'hF);
                end
            end
            prev_ready = bus.o_ready;
        end
    end

    task automatic send(input int v, input logic [3:0] dp, input logic lz, input bit glitch);
        int waited;
        int busy;
        waited = 0;
        busy   = 0;
        @(negedge clk);
        while (!bus.o_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", 32'(bus.o_ready), 32'd1);
        bus.i_value    = 14'(v);
        bus.i_dp       = dp;
        bus.i_lz_blank = lz;
        bus.i_valid    = 1'b1;
        exp_q.push_back(model(v, dp, lz));
        @(negedge clk);
        bus.i_valid = 1'b0;
        while (!bus.o_ready && busy < 100) begin
            busy++;
            if (glitch && busy == 4) begin
                bus.i_value    = 14'(v ^ 14'h155);
                bus.i_dp       = ~dp;
                bus.i_lz_blank = ~lz;
                bus.i_valid    = 1'b1;
            end
            if (busy == 6) bus.i_valid = 1'b0;
            @(negedge clk);
        end
        check("busy_cycles", 32'(busy), 32'd15);
        repeat (WINDOW + 4) @(negedge clk);
    endtask

    task automatic check_blank_scan(input string tag);
        for (int c = 0; c < WINDOW; c++) begin
            @(negedge clk);
            check({tag, "_data"}, 32'(bus.fnd_data), 32'hFF);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int v;
        reset          = 1'b1;
        bus.i_valid    = 1'b0;
        bus.i_value    = '0;
        bus.i_dp       = '0;
        bus.i_lz_blank = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_com", 32'(bus.fnd_com), 32'hF);
        check("rst_data", 32'(bus.fnd_data), 32'hFF);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_ovf", 32'(bus.o_ovf), 32'd0);
        reset = 1'b0;
        check_blank_scan("post_rst");

        send(1234, 4'b0000, 1'b0, 1'b0);
        send(7, 4'b0010, 1'b1, 1'b0);
        send(0, 4'b0000, 1'b1, 1'b0);
        send(10000, 4'b1111, 1'b0, 1'b0);
        send(9999, 4'b0000, 1'b0, 1'b0);
        send(1204, 4'b1000, 1'b1, 1'b0);
        send(16383, 4'b0000, 1'b1, 1'b0);
        send(5678, 4'b0001, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 9));
                1:       v = int'($urandom_range(0, 999));
                2:       v = int'($urandom_range(0, 9999));
                default: v = int'($urandom_range(0, 16383));
            endcase
            send(v, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        send(20000 - 4000, 4'b0000, 1'b0, 1'b0);
        // Reset five cycles into a conversion that follows an overflow display
        @(negedge clk);
        bus.i_value = 14'd4321;
        bus.i_dp    = 4'b0000;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", 32'(bus.o_ready), 32'd0);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_com", 32'(bus.fnd_com), 32'hF);
        check("mid_rst_data", 32'(bus.fnd_data), 32'hFF);
        check("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        check("mid_rst_ovf", 32'(bus.o_ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_blank_scan("mid_rst");
        repeat (20) @(negedge clk);
        check("mid_rst_ovf_hold", 32'(bus.o_ovf), 32'd0);

        send(42, 4'b0100, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
